// File: rtl/arb_pkg.sv
// ---------------------------------------------------------------------------
// arb_pkg
// Shared types and helpers for the round-robin gate arbiter family.
//   state_t      : FSM state encoding (IDLE, GRANT)
//   pick_t       : result of a round-robin search (found flag + index)
//   rr_pick()    : loop-based round-robin search over up to MAX_REQ requests
//   holdCntWidth : width needed for a hold counter that reaches maxHold
// No ports; imported with "import arb_pkg::*;".
// ---------------------------------------------------------------------------
package arb_pkg;

    // Largest requester count any arbiter in this family is built for.
    localparam int MAX_REQ = 16;
    localparam int MAX_IDX_W = $clog2(MAX_REQ);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    typedef struct packed {
        logic                 found;
        logic [MAX_IDX_W-1:0] idx;
    } pick_t;

    // Counter width able to hold the value maxHold itself.
    function automatic int holdCntWidth(input int maxHold);
        return $clog2(maxHold + 1);
    endfunction

    // Reference round-robin search: the first set bit of req at or above ptr,
    // wrapping from nReq-1 back to 0. Bits at or above nReq are ignored.
    function automatic pick_t rr_pick(
        input logic [MAX_REQ-1:0]   req,
        input logic [MAX_IDX_W-1:0] ptr,
        input int                   nReq
    );
        pick_t res;
        int    cand;
        res = '0;
        for (int i = nReq - 1; i >= 0; i--) begin
            cand = int'(ptr) + i;
            if (cand >= nReq) begin
                cand = cand - nReq;
            end
            if (req[cand]) begin
                res.found = 1'b1;
                res.idx   = MAX_IDX_W'(cand);
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// ---------------------------------------------------------------------------
// rr_priority_pick
// Combinational round-robin selector: rotate the request vector so the
// pointer position lands at bit 0, priority-encode the lowest set bit, then
// rotate the index back into requester numbering.
// Ports:
//   i_req   [N-1:0]  request vector
//   i_ptr   [IW-1:0] search start position (must be < N)
//   o_idx   [IW-1:0] chosen requester (0 when nothing is found)
//   o_found          at least one request is set
// ---------------------------------------------------------------------------
module rr_priority_pick #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_ptr,
    output logic [IW-1:0] o_idx,
    output logic          o_found
);

    logic [N-1:0] w_rot;
    int           w_off;
    int           w_sum;

    // Rotation by doubling the vector and shifting right keeps this free of
    // any modulo on the data path; only the final index needs a wrap.
    always_comb begin
        w_rot   = N'({i_req, i_req} >> i_ptr);
        w_off   = 0;
        for (int i = N - 1; i >= 0; i--) begin
            if (w_rot[i]) begin
                w_off = i;
            end
        end
        o_found = |w_rot;
        w_sum   = int'(i_ptr) + w_off;
        if (w_sum >= N) begin
            w_sum = w_sum - N;
        end
        o_idx   = o_found ? IW'(w_sum) : '0;
    end

endmodule

// File: rtl/rr_gate_arbiter.sv
// ---------------------------------------------------------------------------
// rr_gate_arbiter
// Round-robin owner selection for one shared gate resource. A grant is held
// until the owner signals done, drops its request, or the hold limit expires.
// Every release is followed by at least one idle cycle so the resource input
// mux (driven by grant_idx) settles before the next owner.
// Ports:
//   clk                  rising-edge clock
//   rst                  asynchronous active-high reset
//   req       [N_REQ-1:0] level request per requester
//   done                 current owner finished (looked at only in GRANT)
//   grant     [N_REQ-1:0] one-hot grant, zero when idle
//   grant_idx [IDX_W-1:0] owner index, zero when idle
//   busy                 high while a grant is held
//   timeout              one-cycle pulse after a forced release
// ---------------------------------------------------------------------------
module rr_gate_arbiter
    import arb_pkg::*;
#(
    parameter int N_REQ    = 4,
    parameter int MAX_HOLD = 8,
    localparam int IDX_W   = $clog2(N_REQ)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic             done,
    output logic [N_REQ-1:0] grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             busy,
    output logic             timeout
);

    localparam int CNT_W = holdCntWidth(MAX_HOLD);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(N_REQ - 1);

    state_t           r_state;
    logic [N_REQ-1:0] r_grant;
    logic [IDX_W-1:0] r_grantIdx;
    logic             r_busy;
    logic             r_timeout;
    logic [IDX_W-1:0] r_ptr;
    logic [CNT_W-1:0] r_holdCnt;

    logic [IDX_W-1:0] w_pickIdx;
    logic             w_pickFound;
    logic             w_ownerReq;
    logic [IDX_W-1:0] w_nextPtr;

    rr_priority_pick #(
        .N  (N_REQ),
        .IW (IDX_W)
    ) u_pick (
        .i_req   (req),
        .i_ptr   (r_ptr),
        .o_idx   (w_pickIdx),
        .o_found (w_pickFound)
    );

    // Owner's own request and the pointer value to use after its release.
    always_comb begin
        w_ownerReq = req[r_grantIdx];
        w_nextPtr  = (r_grantIdx == LAST_IDX) ? '0 : r_grantIdx + 1'b1;
    end

    // Single FSM: grants from IDLE, releases from GRANT. The release branch
    // always returns to IDLE, which is what guarantees the idle gap between
    // owners. done and an abandoned request are checked before the hold
    // limit so that a cooperative finish never raises timeout.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_grant    <= '0;
            r_grantIdx <= '0;
            r_busy     <= 1'b0;
            r_timeout  <= 1'b0;
            r_ptr      <= '0;
            r_holdCnt  <= '0;
        end else begin
            r_timeout <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_pickFound) begin
                        r_grant    <= {{(N_REQ-1){1'b0}}, 1'b1} << w_pickIdx;
                        r_grantIdx <= w_pickIdx;
                        r_busy     <= 1'b1;
                        r_holdCnt  <= '0;
                        r_state    <= GRANT;
                    end
                end
                GRANT: begin
                    if (done || !w_ownerReq || (r_holdCnt == HOLD_LAST)) begin
                        r_timeout  <= !done && w_ownerReq;
                        r_grant    <= '0;
                        r_grantIdx <= '0;
                        r_busy     <= 1'b0;
                        r_holdCnt  <= '0;
                        r_ptr      <= w_nextPtr;
                        r_state    <= IDLE;
                    end else begin
                        r_holdCnt <= r_holdCnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign grant     = r_grant;
    assign grant_idx = r_grantIdx;
    assign busy      = r_busy;
    assign timeout   = r_timeout;

endmodule

// File: tb/tb_rr_gate_arbiter.sv
// ---------------------------------------------------------------------------
// tb_rr_gate_arbiter
// Directed bench for rr_gate_arbiter with N_REQ=4, MAX_HOLD=8. Inputs change
// and outputs are sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_rr_gate_arbiter;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic       done;
    logic [3:0] grant;
    logic [1:0] grant_idx;
    logic       busy;
    logic       timeout;

    int testsRun;
    int testsFailed;

    rr_gate_arbiter #(
        .N_REQ    (4),
        .MAX_HOLD (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .done      (done),
        .grant     (grant),
        .grant_idx (grant_idx),
        .busy      (busy),
        .timeout   (timeout)
    );

    // 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single comparison point: counts and reports.
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        testsRun++;
        if (got !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic checkState(input string tag, input logic [3:0] expGrant,
                              input logic [1:0] expIdx, input logic expBusy,
                              input logic expTimeout);
        checkOutput({tag, ".grant"}, 32'(grant), 32'(expGrant));
        checkOutput({tag, ".idx"}, 32'(grant_idx), 32'(expIdx));
        checkOutput({tag, ".busy"}, 32'(busy), 32'(expBusy));
        checkOutput({tag, ".timeout"}, 32'(timeout), 32'(expTimeout));
    endtask

    task automatic applyStimulus(input logic [3:0] reqV, input logic doneV);
        req  = reqV;
        done = doneV;
    endtask

    // One rising edge, then return at the following falling edge.
    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    logic [3:0] order [4];
    logic [1:0] orderIdx [4];

    initial begin
        testsRun    = 0;
        testsFailed = 0;
        order    = '{4'b0100, 4'b1000, 4'b0001, 4'b0010};
        orderIdx = '{2'd2, 2'd3, 2'd0, 2'd1};

        // Test 1: reset with all requesting, first grant, done, next grant.
        rst = 1'b1;
        applyStimulus(4'b1111, 1'b0);
        @(negedge clk);
        cycle();
        checkState("t1.reset", 4'b0000, 2'd0, 1'b0, 1'b0);
        rst = 1'b0;
        cycle();
        checkState("t1.first", 4'b0001, 2'd0, 1'b1, 1'b0);
        applyStimulus(4'b1111, 1'b1);
        cycle();
        checkState("t1.gap", 4'b0000, 2'd0, 1'b0, 1'b0);
        applyStimulus(4'b1111, 1'b0);
        cycle();
        checkState("t1.second", 4'b0010, 2'd1, 1'b1, 1'b0);

        // Test 2: full rotation with done each grant and an idle cycle between.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(4'b1111, 1'b1);
            cycle();
            checkState($sformatf("t2.gap%0d", i), 4'b0000, 2'd0, 1'b0, 1'b0);
            applyStimulus(4'b1111, 1'b0);
            cycle();
            checkState($sformatf("t2.grant%0d", i), order[i], orderIdx[i], 1'b1, 1'b0);
        end

        // Test 3: lone requester without done hits the hold limit.
        rst = 1'b1;
        applyStimulus(4'b0100, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        cycle();
        checkState("t3.cyc1", 4'b0100, 2'd2, 1'b1, 1'b0);
        for (int i = 2; i <= 8; i++) begin
            cycle();
            checkState($sformatf("t3.cyc%0d", i), 4'b0100, 2'd2, 1'b1, 1'b0);
        end
        cycle();
        checkState("t3.forced", 4'b0000, 2'd0, 1'b0, 1'b1);
        cycle();
        checkState("t3.regrant", 4'b0100, 2'd2, 1'b1, 1'b0);

        // Test 4: owner 2 abandons while requester 3 waits.
        applyStimulus(4'b1100, 1'b0);
        cycle();
        checkState("t4.held", 4'b0100, 2'd2, 1'b1, 1'b0);
        applyStimulus(4'b1000, 1'b0);
        cycle();
        checkState("t4.drop", 4'b0000, 2'd0, 1'b0, 1'b0);
        cycle();
        checkState("t4.next", 4'b1000, 2'd3, 1'b1, 1'b0);

        // Test 5: done on the same edge as the hold limit.
        for (int i = 2; i <= 8; i++) begin
            cycle();
        end
        checkState("t5.cyc8", 4'b1000, 2'd3, 1'b1, 1'b0);
        applyStimulus(4'b1000, 1'b1);
        cycle();
        checkState("t5.release", 4'b0000, 2'd0, 1'b0, 1'b0);
        applyStimulus(4'b1000, 1'b0);
        cycle();
        checkState("t5.regrant", 4'b1000, 2'd3, 1'b1, 1'b0);

        // Test 6: asynchronous reset mid-grant, then wrap search from pointer 0.
        cycle();
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        checkState("t6.async", 4'b0000, 2'd0, 1'b0, 1'b0);
        cycle();
        checkState("t6.held", 4'b0000, 2'd0, 1'b0, 1'b0);
        rst = 1'b0;
        applyStimulus(4'b1000, 1'b0);
        cycle();
        checkState("t6.wrap", 4'b1000, 2'd3, 1'b1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
